uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Serial UART transmitter: 8N1 frames, LSB first, idle-high line, fixed baud derived from the system clock.
- Accepts one byte per frame through a valid/ready handshake from the MIPSfpga-side peripheral logic and drives the board's TX pin.
- Counterpart of uart_receiver. Shares its clock/baud parameters, so the pair can be looped back for self-test.

Parameters:
- clock_frequency, 50000000, system clock in Hz.
- baud_rate, 9600, line rate in bits/s.
- stop_bits, 1, number of stop-bit periods (1 or 2).
- Derived localparam clock_cycles_in_symbol = clock_frequency / baud_rate (integer division). Values below 2 are unsupported.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- byte_data  input  8  byte to send; sampled only on handshake.
- byte_valid  input  1  requester has a byte; hold high with data stable until accepted.
- byte_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  a frame is in progress (start, data, parity or stop).

Behaviour:
- Reset (async, reset_n=0), all outputs immediate and not clock-dependent:
  - tx=1, busy=0, byte_ready=0 while reset is asserted.
  - Counter=0, shift register cleared, state IDLE.
  - Deassertion is synchronous to clock. byte_ready=1 from the first edge after release.
- States: IDLE, START, DATA, PARITY (only with feature), STOP.
- byte_ready = 1 only in IDLE (combinational from state register). busy = not IDLE.
- Handshake: at a posedge with state IDLE and byte_valid=1, byte_data is latched into an 8-bit shift register. From that edge on:
  - state=START, tx=0.
  - Symbol counter loaded with clock_cycles_in_symbol.
- Symbol counter: decrements every clock. A symbol ends when counter==1; on that edge it reloads with clock_cycles_in_symbol and the state advances. Each symbol therefore lasts exactly clock_cycles_in_symbol cycles on tx.
- START -> DATA: tx=shift[0]; bit index 0.
- DATA: at each symbol end:
  - Shift register shifts right and the bit index increments.
  - tx = next LSB.
  - After bit index 7 ends, go to STOP (or PARITY), tx=1.
- STOP: tx=1 for stop_bits*clock_cycles_in_symbol cycles (stop counter), then IDLE.
- IDLE: tx=1. Counter holds 0.
- Frame length, handshake edge to return to IDLE: (10 + stop_bits - 1) * clock_cycles_in_symbol cycles, plus one symbol with parity.
- Back-to-back: if byte_valid stays high, the next byte is accepted on the first IDLE cycle. The inter-frame gap is exactly 1 extra idle-high clock beyond the stop period.
- byte_data changes while busy are ignored. byte_valid while busy is not lost; it is accepted at the next IDLE.
- Reset mid-frame aborts immediately: tx=1 asynchronously and the partial byte is discarded. The receiver sees a truncated frame, which is acceptable.
- No glitches on tx: tx is driven only from a flop.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA for one symbol.
  - tx = even parity: XOR of the 8 latched bits, computed at accept time and held in a flop.
  - Frame is 8E1.
- Undefined:
  - No PARITY state and no parity flop.
  - Frame is 8N1, fully compatible with uart_receiver.

Decomposition:
- Shared package/include uart_pkg:
  - State encoding localparams (IDLE/START/DATA/PARITY/STOP).
  - clock_cycles_in_symbol computation.
  - Defaults for clock_frequency and baud_rate.
  - uart_receiver later includes the same file.
- One natural sub-module: uart_baud_counter.
  - Loadable down-counter with load and load_value inputs and a done output (counter==1).
  - Reusable by the receiver's half-symbol load.

Test Plan:
- Reset: hold reset_n=0 mid-simulation -> tx=1, busy=0, byte_ready=0 immediately. After release, byte_ready=1 on the next edge.
- Single frame, clock_frequency=1000, baud_rate=100 (10 cycles/bit), send 0x55:
  - tx sequence per 10-cycle symbol = 0,1,0,1,0,1,0,1,0,1.
  - busy high for exactly 100 cycles.
  - byte_ready low during the frame.
- Back-to-back: byte_valid held high with 0xA5 then 0x3C -> second start bit falls exactly 101 cycles after first acceptance. Bits decode LSB-first to A5, 3C.
- Data stability: change byte_data mid-frame to 0xFF -> transmitted byte stays the originally latched value.
- Reset mid-frame: assert reset_n=0 during bit 4 -> tx=1 within the same time step. After release, a new 0x81 frame is sent cleanly.
- Loopback:
  - Connect tx to uart_receiver rx at 50 MHz/9600, send 0x00, 0xFF, 0x5A -> receiver byte_ready pulses once per byte with matching data.
  - With UART_TX_PARITY_EN, 0x07 produces a parity symbol of 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - Default clock frequency / baud rate.
//   - FSM state encoding (IDLE/START/DATA/PARITY/STOP).
//   - Helpers that derive the symbol length and the counter width.
// No ports (package).
package uart_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE       = 9600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit period (integer division, values below 2 unsupported).
    function automatic int unsigned cycles_in_symbol(input int unsigned clock_frequency,
                                                     input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // Bits needed to hold the value 'cycles' in a down-counter.
    function automatic int unsigned counter_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: loadable down-counter that times one UART symbol.
// Ports:
//   clock       in   system clock (posedge)
//   reset_n     in   asynchronous active-low reset
//   load        in   load load_value on this edge (has priority over counting)
//   load_value  in   value to load (symbol length, or half a symbol in the receiver)
//   done        out  counter currently equals 1: the edge that sees it ends the symbol
// The counter decrements every clock and stops at 0 so an idle user can leave it parked.
module uart_baud_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter, LSB first, idle-high line.
// Optional feature macro: UART_TX_PARITY_EN -> adds an even-parity symbol (8E1).
// Ports:
//   clock       in   system clock (posedge)
//   reset_n     in   asynchronous active-low reset; forces tx=1, busy=0, byte_ready=0
//   byte_data   in   [7:0] byte to send, sampled only on the handshake edge
//   byte_valid  in   requester has a byte (hold until accepted)
//   byte_ready  out  transmitter accepts a byte this cycle (IDLE only)
//   tx          out  serial line, driven straight from a flop
//   busy        out  a frame is in progress
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned clock_frequency = DEFAULT_CLOCK_FREQUENCY,
    parameter int unsigned baud_rate       = DEFAULT_BAUD_RATE,
    parameter int unsigned stop_bits       = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned     CYCLES      = cycles_in_symbol(clock_frequency, baud_rate);
    localparam int unsigned     CNT_W       = counter_width(CYCLES);
    localparam logic [CNT_W-1:0] SYMBOL_LOAD = CNT_W'(CYCLES);
    // The bit index doubles as the stop-symbol index while in STOP.
    localparam logic [2:0]      STOP_LAST   = 3'(stop_bits - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        ready_en_q;
    logic        symbol_load;
    logic        symbol_done;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    uart_baud_counter #(
        .WIDTH(CNT_W)
    ) u_baud_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (symbol_load),
        .load_value (SYMBOL_LOAD),
        .done       (symbol_done)
    );

    // ready_en_q keeps byte_ready low during reset and until the first edge after release,
    // even though the state register already sits in IDLE.
    assign byte_ready = ready_en_q && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign tx         = tx_q;
    assign accept     = byte_ready && byte_valid;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        symbol_load = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d     = ST_START;
                    shift_d     = byte_data;
                    bit_idx_d   = 3'd0;
                    tx_d        = 1'b0;
                    symbol_load = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d    = ^byte_data;
`endif
                end
            end
            ST_START: begin
                if (symbol_done) begin
                    state_d     = ST_DATA;
                    bit_idx_d   = 3'd0;
                    tx_d        = shift_q[0];
                    symbol_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (symbol_done) begin
                    symbol_load = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        // Next LSB is bit 1 of the current register, i.e. bit 0 after the shift.
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (symbol_done) begin
                    state_d     = ST_STOP;
                    bit_idx_d   = 3'd0;
                    tx_d        = 1'b1;
                    symbol_load = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (symbol_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        // No reload: the counter runs down to 0 and stays there in IDLE.
                        state_d   = ST_IDLE;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d   = bit_idx_q + 3'd1;
                        symbol_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            ready_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            ready_en_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule
